// File: rtl/eaglesong_pkg.sv
// rtl/eaglesong_pkg.sv - shared Eaglesong rate constants and the block record
package eaglesong_pkg;

  localparam int EAGLESONG_RATE_BYTES = 32;
  localparam int EAGLESONG_RATE_BITS  = 256;

  typedef struct packed {
    logic [EAGLESONG_RATE_BITS-1:0] data;
    logic [6:0]                     length_bytes;
    logic [7:0]                     round_num;
    logic                           last;
  } eaglesong_blk_t;

endpackage

// File: rtl/eaglesong_msg_packer_if.sv
// rtl/eaglesong_msg_packer_if.sv - byte intake and block output streams of the message packer
interface eaglesong_msg_packer_if;
  import eaglesong_pkg::*;

  logic                           in_valid;
  logic                           in_ready;
  logic [7:0]                     in_data;
  logic                           in_last;
  logic                           blk_valid;
  logic                           blk_ready;
  logic [EAGLESONG_RATE_BITS-1:0] blk_data;
  logic [6:0]                     blk_length_bytes;
  logic [7:0]                     blk_round_num;
  logic                           blk_last;

  modport master (
    output in_valid, in_data, in_last, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_length_bytes, blk_round_num, blk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, blk_ready,
    output in_ready, blk_valid, blk_data, blk_length_bytes, blk_round_num, blk_last
  );

endinterface

// File: rtl/eaglesong_blk_reg.sv
// rtl/eaglesong_blk_reg.sv - valid/ready holding register for one finished block
module eaglesong_blk_reg
  import eaglesong_pkg::*;
#(
  parameter type blk_t = eaglesong_blk_t
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  blk_t load_blk_i,
  input  logic ready_i,
  output logic valid_o,
  output blk_t blk_o
);

  logic valid_q, valid_d;
  blk_t blk_q, blk_d;

  // The caller only loads when the register is empty or being drained this cycle.
  always_comb begin
    valid_d = valid_q;
    blk_d   = blk_q;
    if (load_i) begin
      valid_d = 1'b1;
      blk_d   = load_blk_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      blk_q   <= '0;
    end else begin
      valid_q <= valid_d;
      blk_q   <= blk_d;
    end
  end

  assign valid_o = valid_q;
  assign blk_o   = blk_q;

endmodule

// File: rtl/eaglesong_msg_packer.sv
// rtl/eaglesong_msg_packer.sv - packs a byte stream into 256-bit Eaglesong rate blocks
// Optional EAGLESONG_PACKER_STATS_EN adds the completed-message counter.
module eaglesong_msg_packer
  import eaglesong_pkg::*;
#(
  parameter int RATE_BYTES = EAGLESONG_RATE_BYTES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  eaglesong_msg_packer_if.slave  bus,
  output logic                   err_round_ovf,
  output logic [15:0]            msg_count
);

  localparam logic [5:0] FULL_CNT = 6'(RATE_BYTES);

  logic [EAGLESONG_RATE_BITS-1:0] acc_q, acc_d, merge_data;
  logic [5:0]                     acc_cnt_q, acc_cnt_d, merge_cnt;
  logic                           acc_last_q, acc_last_d, merge_last;
  logic [7:0]                     round_q, round_d;
  logic                           err_q, err_d;
  logic                           acc_done_q, out_free, accept, transfer;
  eaglesong_blk_t                 xfer_blk, out_blk;
  logic                           out_valid;

  assign acc_done_q  = (acc_cnt_q == FULL_CNT) || acc_last_q;
  assign out_free    = !out_valid || bus.blk_ready;
  assign bus.in_ready = !(acc_done_q && !out_free);
  assign accept      = bus.in_valid && bus.in_ready;

  // The incoming byte is merged before the completion test so a block can
  // reach the output register on the same edge that accepts its last byte.
  always_comb begin
    merge_data = acc_q;
    merge_cnt  = acc_cnt_q;
    merge_last = acc_last_q;
    if (accept && !acc_done_q) begin
      merge_data[{acc_cnt_q[4:0], 3'b000} +: 8] = bus.in_data;
      merge_cnt  = acc_cnt_q + 6'd1;
      merge_last = acc_last_q | bus.in_last;
    end
  end

  assign transfer = out_free && ((merge_cnt == FULL_CNT) || merge_last);

  always_comb begin
    xfer_blk              = '0;
    xfer_blk.data         = merge_data;
    xfer_blk.length_bytes = {1'b0, merge_cnt};
    xfer_blk.round_num    = round_q;
    xfer_blk.last         = merge_last;
  end

  // A byte accepted while a stalled complete block leaves starts the cleared accumulator.
  always_comb begin
    acc_d      = merge_data;
    acc_cnt_d  = merge_cnt;
    acc_last_d = merge_last;
    round_d    = round_q;
    err_d      = err_q;
    if (transfer) begin
      acc_d      = '0;
      acc_cnt_d  = '0;
      acc_last_d = 1'b0;
      if (accept && acc_done_q) begin
        acc_d[7:0] = bus.in_data;
        acc_cnt_d  = 6'd1;
        acc_last_d = bus.in_last;
      end
      if (merge_last) begin
        round_d = '0;
      end else if (round_q == 8'hFF) begin
        err_d = 1'b1;
      end else begin
        round_d = round_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q      <= '0;
      acc_cnt_q  <= '0;
      acc_last_q <= 1'b0;
      round_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_last_q <= acc_last_d;
      round_q    <= round_d;
      err_q      <= err_d;
    end
  end

  eaglesong_blk_reg #(.blk_t(eaglesong_blk_t)) u_blk_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (transfer),
    .load_blk_i (xfer_blk),
    .ready_i    (bus.blk_ready),
    .valid_o    (out_valid),
    .blk_o      (out_blk)
  );

  assign bus.blk_valid        = out_valid;
  assign bus.blk_data         = out_blk.data;
  assign bus.blk_length_bytes = out_blk.length_bytes;
  assign bus.blk_round_num    = out_blk.round_num;
  assign bus.blk_last         = out_blk.last;
  assign err_round_ovf        = err_q;

`ifdef EAGLESONG_PACKER_STATS_EN
  logic [15:0] msg_cnt_q, msg_cnt_d;

  always_comb begin
    msg_cnt_d = msg_cnt_q;
    if (out_valid && bus.blk_ready && out_blk.last) begin
      msg_cnt_d = msg_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msg_cnt_q <= '0;
    end else begin
      msg_cnt_q <= msg_cnt_d;
    end
  end

  assign msg_count = msg_cnt_q;
`else
  assign msg_count = '0;
`endif

endmodule

// File: tb/tb_eaglesong_msg_packer.sv
// tb/tb_eaglesong_msg_packer.sv - scoreboard bench for the Eaglesong message packer
module tb_eaglesong_msg_packer;
  import eaglesong_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        err_round_ovf;
  logic [15:0] msg_count;

  eaglesong_msg_packer_if bus();

  eaglesong_msg_packer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .err_round_ovf (err_round_ovf),
    .msg_count     (msg_count)
  );

  int             total = 0;
  int             bad = 0;
  int             rdy_mode = 0;
  eaglesong_blk_t exp_q[$];
  logic [7:0]     msg[$];
  logic           exp_err = 1'b0;
  int             exp_msgs = 0;
  eaglesong_blk_t got, exp_blk, held;
  logic           held_v = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // blk_ready: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    bus.blk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.blk_ready = 1'b1;
        1:       bus.blk_ready = 1'($urandom_range(0, 1));
        default: bus.blk_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: a message of n bytes is cut into ceil(n/32) chunks in order.
  task automatic model_push();
    int n, nb, len;
    eaglesong_blk_t b;
    n  = msg.size();
    nb = (n + 31) / 32;
    for (int i = 0; i < nb; i++) begin
      len = (n - 32 * i > 32) ? 32 : n - 32 * i;
      b = '0;
      for (int k = 0; k < len; k++) b.data[8 * k +: 8] = msg[32 * i + k];
      b.length_bytes = 7'(len);
      b.round_num    = 8'((i > 255) ? 255 : i);
      b.last         = (i == nb - 1);
      exp_q.push_back(b);
    end
    if (nb > 256) exp_err = 1'b1;
    exp_msgs++;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, output int waits);
    logic ok;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 3000) begin
        total++;
        bad++;
        $display("FAIL in_handshake_timeout: byte %0h never accepted", d);
        break;
      end
    end
    waits = n;
  endtask

  task automatic run_msg(output int stalls);
    int w;
    stalls = 0;
    model_push();
    for (int i = 0; i < msg.size(); i++) begin
      send_byte(msg[i], (i == msg.size() - 1), w);
      stalls += w;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    rdy_mode = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d blocks still expected, required 0", exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blk_valid"}, 256'(bus.blk_valid), 256'(0));
    check({tag, "_blk_data"}, bus.blk_data, 256'(0));
    check({tag, "_blk_len"}, 256'(bus.blk_length_bytes), 256'(0));
    check({tag, "_blk_round"}, 256'(bus.blk_round_num), 256'(0));
    check({tag, "_blk_last"}, 256'(bus.blk_last), 256'(0));
    check({tag, "_err"}, 256'(err_round_ovf), 256'(0));
    check({tag, "_msg_count"}, 256'(msg_count), 256'(0));
  endtask

  task automatic check_msg_count(input string nm);
    int req;
`ifdef EAGLESONG_PACKER_STATS_EN
    req = exp_msgs;
`else
    req = 0;
`endif
    check(nm, 256'(msg_count), 256'(req));
  endtask

  // Monitor: compares every output handshake and holds stalled blocks steady.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held_v = 1'b0;
      end else begin
        got = '0;
        got.data         = bus.blk_data;
        got.length_bytes = bus.blk_length_bytes;
        got.round_num    = bus.blk_round_num;
        got.last         = bus.blk_last;
        if (held_v) begin
          total++;
          if (!bus.blk_valid || got != held) begin
            bad++;
            $display("FAIL stall_hold: valid=%0b len=%0d round=%0d, required held len=%0d round=%0d",
                     bus.blk_valid, got.length_bytes, got.round_num, held.length_bytes, held.round_num);
          end
        end
        held_v = bus.blk_valid && !bus.blk_ready;
        held   = got;
        if (bus.blk_valid && bus.blk_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL blk_unexpected: got len=%0d round=%0d, required no block",
                     got.length_bytes, got.round_num);
          end else begin
            exp_blk = exp_q.pop_front();
            if (got != exp_blk) begin
              bad++;
              $display("FAIL blk: got data=%0h len=%0d round=%0d last=%0b, expected data=%0h len=%0d round=%0d last=%0b",
                       got.data, got.length_bytes, got.round_num, got.last,
                       exp_blk.data, exp_blk.length_bytes, exp_blk.round_num, exp_blk.last);
            end
          end
        end
      end
    end
  end

  initial begin
    int st, w;
    string hello;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    reset_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    #1;
    check("reset_in_ready", 256'(bus.in_ready), 256'(1));

    hello = "Hello, world!\n";
    msg.delete();
    for (int i = 0; i < hello.len(); i++) msg.push_back(hello[i]);
    run_msg(st);
    check("hello_latency_valid", 256'(bus.blk_valid), 256'(1));
    check("hello_data", bus.blk_data, 256'h0A21646C726F77202C6F6C6C6548);
    wait_drain();

    msg.delete();
    for (int i = 0; i < 32; i++) msg.push_back(8'(i));
    run_msg(st);
    wait_drain();

    msg.delete();
    for (int i = 0; i < 40; i++) msg.push_back(8'(i));
    run_msg(st);
    check("multi_no_stall", 256'(st), 256'(0));
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back(8'(8'hA0 + i));
    run_msg(st);
    check("contig_no_stall", 256'(st), 256'(0));
    wait_drain();

    rdy_mode = 2;
    @(posedge clk);
    #1;
    msg.delete();
    for (int i = 0; i < 70; i++) msg.push_back(8'($urandom));
    model_push();
    for (int i = 0; i < 70; i++) begin
      send_byte(msg[i], (i == 69), w);
      if (i == 63) begin
        check("bp_in_ready_low", 256'(bus.in_ready), 256'(0));
        rdy_mode = 0;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    wait_drain();

    rdy_mode = 1;
    for (int m = 0; m < 12; m++) begin
      msg.delete();
      for (int i = 0, n = (m == 5) ? 64 : $urandom_range(1, 100); i < n; i++)
        msg.push_back(8'($urandom));
      run_msg(st);
    end
    wait_drain();
    check_msg_count("msg_count_random");

    rdy_mode = 2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 42; i++) send_byte(8'(8'h50 + i), 1'b0, w);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_err  = 1'b0;
    exp_msgs = 0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("midreset_in_ready", 256'(bus.in_ready), 256'(1));
    msg.delete();
    msg.push_back(8'h11);
    msg.push_back(8'h22);
    msg.push_back(8'h33);
    run_msg(st);
    wait_drain();

    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    exp_err  = 1'b0;
    exp_msgs = 0;
    msg.delete();
    for (int i = 0; i < 257 * 32 + 1; i++) msg.push_back(8'($urandom));
    run_msg(st);
    wait_drain();
    check("ovf_err", 256'(err_round_ovf), 256'(exp_err));
    check_msg_count("ovf_msg_count");
    msg.delete();
    for (int i = 0; i < 7; i++) msg.push_back(8'(i + 1));
    run_msg(st);
    wait_drain();
    check("ovf_err_sticky", 256'(err_round_ovf), 256'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
